// File: rtl/fixed_to_fp_if.sv
// Handshake bundle for the fixed-point to IEEE-754 single converter.
// The slave side is the converter, the master side is the testbench or upstream logic.
interface fixed_to_fp_if #(
  parameter int FRAC_W = 19
);
  logic              in_valid;
  logic              in_ready;
  logic              sign_i;
  logic              integer_i;
  logic [FRAC_W-1:0] fractional_i;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       fp_o;

  modport slave (
    input  in_valid, sign_i, integer_i, fractional_i, out_ready,
    output in_ready, out_valid, fp_o
  );

  modport master (
    output in_valid, sign_i, integer_i, fractional_i, out_ready,
    input  in_ready, out_valid, fp_o
  );
endinterface

// File: rtl/fixed_to_fp.sv
// Sign-magnitude 1.FRAC_W fixed point to IEEE-754 single.
// Normalises with one left shift per cycle; the result is exact.
module fixed_to_fp #(
  parameter int FRAC_W   = 19,
  parameter int EXP_BIAS = 127
) (
  input  logic          clk,
  input  logic          rst_n,
  fixed_to_fp_if.slave  io
);
  localparam int         MW    = FRAC_W + 1;
  localparam logic [7:0] BIAS8 = 8'(EXP_BIAS);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t          state, state_nx;
  logic [MW-1:0]   m, m_nx;
  logic [7:0]      exp_q, exp_nx;
  logic            sign_q, sign_nx;
  logic [31:0]     fp_q, fp_nx;
  logic            ov_q, ov_nx;
  logic [MW-1:0]   m_in;
  logic [22:0]     frac_field;

  assign m_in       = {io.integer_i, io.fractional_i};
  // Drop the hidden one and left-align the remaining bits in the 23-bit field.
  assign frac_field = 23'(m[MW-2:0]) << (23 - FRAC_W);

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = ov_q;
  assign io.fp_o      = fp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      fp_q   <= '0;
      ov_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      m      <= m_nx;
      exp_q  <= exp_nx;
      sign_q <= sign_nx;
      fp_q   <= fp_nx;
      ov_q   <= ov_nx;
    end
  end

  always_comb begin
    state_nx = state;
    m_nx     = m;
    exp_nx   = exp_q;
    sign_nx  = sign_q;
    fp_nx    = fp_q;
    ov_nx    = ov_q;
    unique case (state)
      IDLE: begin
        if (io.in_valid) begin
          sign_nx = io.sign_i;
          m_nx    = m_in;
          exp_nx  = BIAS8;
          if (m_in == '0) begin
            // Zero has no leading one to find; emit signed zero directly.
            fp_nx    = {io.sign_i, 31'b0};
            ov_nx    = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = NORM;
          end
        end
      end
      NORM: begin
        if (m[MW-1]) begin
          fp_nx    = {sign_q, exp_q, frac_field};
          ov_nx    = 1'b1;
          state_nx = DONE;
        end else begin
          m_nx   = m << 1;
          exp_nx = exp_q - 8'd1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          ov_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fixed_to_fp.sv
// Self-checking bench for fixed_to_fp: vector table through a scoreboard,
// plus hand sequences for backpressure, busy in_ready and reset abort.
module tb_fixed_to_fp;
  localparam int FW = 19;

  typedef struct {
    logic          s;
    logic          i;
    logic [FW-1:0] f;
    logic [31:0]   fp;
    int            lat;
  } vec_t;

  typedef struct {
    logic [31:0] fp;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_ov = 1'b0;
  exp_t sb[$];
  vec_t vecs[10];

  fixed_to_fp_if #(.FRAC_W(FW)) io ();

  fixed_to_fp #(.FRAC_W(FW), .EXP_BIAS(127)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: compares each new result against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && io.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %h want none", io.fp_o);
        end else begin
          e = sb.pop_front();
          chk("fp_o", io.fp_o, e.fp);
          chk("latency", 32'(cyc), 32'(e.due));
        end
      end
      prev_ov = rst_n && io.out_valid;
    end
  end

  task automatic send(input logic s, input logic i, input logic [FW-1:0] f,
                      input logic [31:0] efp, input int lat);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (!io.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!io.in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    io.in_valid     = 1'b1;
    io.sign_i       = s;
    io.integer_i    = i;
    io.fractional_i = f;
    @(posedge clk);
    #1;
    e.fp  = efp;
    e.due = cyc + lat;
    sb.push_back(e);
    io.in_valid     = 1'b0;
    io.sign_i       = ~s;
    io.fractional_i = ~f;
  endtask

  task automatic wait_ov(input string name);
    int t = 0;
    while (!io.out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!io.out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got 0 want 1", name);
    end
  endtask

  initial begin
    int   t;
    logic busy_ok;
    vecs[0] = '{1'b0, 1'b1, 19'h00000, 32'h3F800000, 1};
    vecs[1] = '{1'b0, 1'b1, 19'h7FFFF, 32'h3FFFFFF0, 1};
    vecs[2] = '{1'b1, 1'b0, 19'h60000, 32'hBF400000, 2};
    vecs[3] = '{1'b1, 1'b0, 19'h00000, 32'h80000000, 0};
    vecs[4] = '{1'b0, 1'b0, 19'h00000, 32'h00000000, 0};
    vecs[5] = '{1'b0, 1'b0, 19'h40000, 32'h3F000000, 2};
    vecs[6] = '{1'b0, 1'b1, 19'h40000, 32'h3FC00000, 1};
    vecs[7] = '{1'b1, 1'b1, 19'h20000, 32'hBFA00000, 1};
    vecs[8] = '{1'b0, 1'b0, 19'h18000, 32'h3E400000, 4};
    vecs[9] = '{1'b1, 1'b0, 19'h00001, 32'hB6000000, 20};

    io.in_valid     = 1'b0;
    io.sign_i       = 1'b0;
    io.integer_i    = 1'b0;
    io.fractional_i = '0;
    io.out_ready    = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_fp_o", io.fp_o, 32'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++)
      send(vecs[v].s, vecs[v].i, vecs[v].f, vecs[v].fp, vecs[v].lat);

    // Smallest nonzero: in_ready must stay low for the whole normalisation.
    send(1'b0, 1'b0, 19'h00001, 32'h36000000, 20);
    busy_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (io.in_ready) busy_ok = 1'b0;
    end
    chk("busy_in_ready_low", 32'(busy_ok), 32'd1);

    // Backpressure with ignored input pulses.
    repeat (25) @(negedge clk);
    io.out_ready = 1'b0;
    send(1'b0, 1'b1, 19'h00000, 32'h3F800000, 1);
    @(negedge clk);
    wait_ov("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_fp_hold", io.fp_o, 32'h3F800000);
      chk("bp_ov_hold", 32'(io.out_valid), 32'd1);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
      io.in_valid     = (k % 2 == 0);
      io.sign_i       = 1'b1;
      io.integer_i    = 1'b0;
      io.fractional_i = 19'h12345;
      @(negedge clk);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ov_drop", 32'(io.out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(io.in_ready), 32'd1);
    chk("bp_fp_keep", io.fp_o, 32'h3F800000);
    repeat (30) @(negedge clk);

    // Asynchronous reset mid-conversion.
    send(1'b0, 1'b0, 19'h00001, 32'h36000000, 20);
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ov", 32'(io.out_valid), 32'd0);
    chk("abort_fp", io.fp_o, 32'h0);
    chk("abort_in_ready", 32'(io.in_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 1'b1, 19'h00000, 32'h3F800000, 1);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
